// File: rtl/row_assembler_i_if.sv
// Valid/ready bundle for row_assembler_i: the narrow beat stream in, the completed row out.
// master = upstream/downstream environment, slave = the assembler.
interface row_assembler_i_if #(
  parameter int WIDTH    = 16,
  parameter int COL      = 256,
  parameter int IN_WORDS = 4
);
  logic                      s_valid;
  logic                      s_ready;
  logic [WIDTH*IN_WORDS-1:0] s_data;
  logic                      s_last;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH*COL-1:0]      out_data;

  modport master (
    output s_valid, s_data, s_last, out_ready,
    input  s_ready, out_valid, out_data
  );

  modport slave (
    input  s_valid, s_data, s_last, out_ready,
    output s_ready, out_valid, out_data
  );
endinterface

// File: rtl/row_assembler_i.sv
// Packs IN_WORDS-element beats into WIDTH*COL-bit rows behind a one-row output slot.
// Optional s_last framing check: define ROW_ASSEMBLER_LAST_CHECK_EN.
module row_assembler_i #(
  parameter int WIDTH    = 16,
  parameter int COL      = 256,
  parameter int ROW      = 2754,
  parameter int IN_WORDS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  row_assembler_i_if.slave         bus,
  output logic [$clog2(ROW+1)-1:0] row_count,
  output logic                     done,
  output logic                     err
);
  localparam int BEATS  = COL / IN_WORDS;
  localparam int BEAT_W = WIDTH * IN_WORDS;
  localparam int ROW_W  = WIDTH * COL;
  localparam int BCW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RCW    = $clog2(ROW + 1);

  typedef enum logic [1:0] {IDLE, ASM, HOLD, DONE} state_t;

  state_t           state, state_nxt;
  logic [BCW-1:0]   beat_cnt;
  logic [RCW-1:0]   rows_in;
  logic [ROW_W-1:0] asm_row;
  logic [ROW_W-1:0] row_full;
  logic [ROW_W-1:0] hold_row;
  logic             accept, row_end, slot_free, out_hs, last_row;
  logic             load_asm, load_hold, park;

  assign accept    = bus.s_valid & bus.s_ready;
  assign row_end   = accept & (beat_cnt == BCW'(BEATS - 1));
  assign slot_free = ~bus.out_valid | bus.out_ready;
  assign out_hs    = bus.out_valid & bus.out_ready;
  assign last_row  = (rows_in == RCW'(ROW - 1));
  assign load_asm  = (state == ASM) & row_end & slot_free;
  assign park      = (state == ASM) & row_end & ~slot_free;
  assign load_hold = (state == HOLD) & out_hs;

  // Final beat is merged combinationally so a completed row reaches the slot in one cycle.
  always_comb begin
    row_full = asm_row;
    row_full[ROW_W-1 - int'(beat_cnt)*BEAT_W -: BEAT_W] = bus.s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = ASM;
      ASM: begin
        if (load_asm && last_row) state_nxt = DONE;
        else if (park)            state_nxt = HOLD;
      end
      HOLD: if (out_hs) state_nxt = last_row ? DONE : ASM;
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    bus.s_ready = 1'b0;
    if (state == ASM) bus.s_ready = en;
    done = (state == DONE) & ~bus.out_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt      <= '0;
      rows_in       <= '0;
      row_count     <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
    end else begin
      if (accept)
        beat_cnt <= (beat_cnt == BCW'(BEATS - 1)) ? '0 : beat_cnt + 1'b1;
      if (load_asm || load_hold)
        rows_in <= rows_in + 1'b1;
      if (out_hs)
        row_count <= row_count + 1'b1;
      if (load_asm || load_hold)
        bus.out_valid <= 1'b1;
      else if (bus.out_ready)
        bus.out_valid <= 1'b0;
      if (load_asm)
        bus.out_data <= row_full;
      else if (load_hold)
        bus.out_data <= hold_row;
    end
  end

  // Assembly and hold buffers need no reset: beat_cnt restarts and overwrites every slot.
  always_ff @(posedge clk) begin
    if (accept) asm_row  <= row_full;
    if (park)   hold_row <= row_full;
  end

`ifdef ROW_ASSEMBLER_LAST_CHECK_EN
  logic final_beat;
  assign final_beat = row_end & last_row;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      err <= 1'b0;
    else if (accept && (bus.s_last != final_beat)) err <= 1'b1;
  end
`else
  logic unused_last;
  assign unused_last = bus.s_last;
  assign err         = 1'b0;
`endif
endmodule

// File: tb/tb_row_assembler_i.sv
// Scoreboard bench for row_assembler_i: stimulus queues expected rows, a monitor pops them on handshakes.
module tb_row_assembler_i;
  localparam int WIDTH    = 16;
  localparam int COL      = 8;
  localparam int ROW      = 4;
  localparam int IN_WORDS = 4;
  localparam int BEATS    = COL / IN_WORDS;
  localparam int RCW      = $clog2(ROW + 1);
`ifdef ROW_ASSEMBLER_LAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef logic [WIDTH-1:0] row_t [COL];

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic [RCW-1:0] row_count;
  logic           done;
  logic           err;

  row_assembler_i_if #(.WIDTH(WIDTH), .COL(COL), .IN_WORDS(IN_WORDS)) bus ();

  row_assembler_i #(.WIDTH(WIDTH), .COL(COL), .ROW(ROW), .IN_WORDS(IN_WORDS)) dut (
    .clk(clk), .rst(rst), .en(en), .bus(bus),
    .row_count(row_count), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int                     n_vec = 0;
  int                     n_bad = 0;
  bit                     rnd_rdy = 1'b0;
  bit                     rnd_gap = 1'b0;
  logic [WIDTH*COL-1:0]   exp_q [$];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Reference view: a row is just COL elements, element 0 leftmost.
  function automatic logic [WIDTH*COL-1:0] pack_row(input row_t e);
    logic [WIDTH*COL-1:0] r;
    r = '0;
    for (int i = 0; i < COL; i++) r = (r << WIDTH) | (WIDTH*COL)'(e[i]);
    return r;
  endfunction

  function automatic logic [WIDTH*IN_WORDS-1:0] pack_beat(input row_t e, input int b);
    logic [WIDTH*IN_WORDS-1:0] r;
    r = '0;
    for (int i = 0; i < IN_WORDS; i++) r = (r << WIDTH) | (WIDTH*IN_WORDS)'(e[b*IN_WORDS + i]);
    return r;
  endfunction

  task automatic seq_row(input int r, output row_t e);
    for (int i = 0; i < COL; i++) e[i] = WIDTH'(r*COL + i + 1);
  endtask

  task automatic rand_row(output row_t e);
    for (int i = 0; i < COL; i++) e[i] = WIDTH'($urandom);
  endtask

  task automatic send_beat(input logic [WIDTH*IN_WORDS-1:0] d, input bit lst);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    if (rnd_gap && $urandom_range(0, 2) == 0) begin
      bus.s_valid = 1'b0;
      tick();
    end
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = lst;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.s_ready;
      tick();
      n++;
    end
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL beat_accept: s_ready stayed 0 for %0d cycles, required 1", n);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  // last_beat: index of the beat carrying s_last, or -1 for none.
  task automatic send_row(input row_t e, input int last_beat);
    for (int b = 0; b < BEATS; b++) send_beat(pack_beat(e, b), b == last_beat);
    exp_q.push_back(pack_row(e));
  endtask

  task automatic do_reset();
    #1;
    rst = 1'b1;
    en = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_last = 1'b0;
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic end_matrix(input bit exp_err);
    int n;
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (!done && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("done", done, 1'b1);
    chk("done_s_ready", bus.s_ready, 1'b0);
    chk("done_out_valid", bus.out_valid, 1'b0);
    chk("done_row_count", row_count, ROW);
    chk("queue_empty", exp_q.size(), 0);
    chk("err", err, exp_err);
  endtask

  // Monitor: pops the expected row on every out handshake and tracks row_count / stall stability.
  initial begin
    logic [WIDTH*COL-1:0] prev_data;
    bit prev_stall;
    int exp_rc;
    prev_data = '0;
    prev_stall = 1'b0;
    exp_rc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_rc = 0;
        prev_stall = 1'b0;
      end else begin
        chk("row_count", row_count, exp_rc);
        if (prev_stall) begin
          chk("stall_valid", bus.out_valid, 1'b1);
          chk("stall_data", bus.out_data, prev_data);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_row: got %0h, required no row", bus.out_data);
          end else begin
            chk("row_data", bus.out_data, exp_q.pop_front());
          end
          exp_rc++;
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data = bus.out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    row_t e, e1;
    rst = 1'b1;
    en = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = '0;
    bus.s_last = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_s_ready", bus.s_ready, 1'b0);
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_row_count", row_count, 0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    tick();
    tick();
    rst = 1'b0;
    repeat (3) begin
      tick();
      chk("idle_s_ready", bus.s_ready, 1'b0);
    end
    en = 1'b1;
    tick();
    chk("asm_s_ready", bus.s_ready, 1'b1);

    // Streaming with sequential elements
    bus.out_ready = 1'b1;
    for (int r = 0; r < ROW; r++) begin
      seq_row(r, e);
      send_row(e, (r == ROW-1) ? BEATS-1 : -1);
      if (r == 0) begin
        chk("latency_valid", bus.out_valid, 1'b1);
        chk("row0_literal", bus.out_data, 128'h0001_0002_0003_0004_0005_0006_0007_0008);
      end
    end
    end_matrix(1'b0);

    // Backpressure into HOLD
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b0;
    rand_row(e);
    send_row(e, -1);
    rand_row(e1);
    send_row(e1, -1);
    chk("bp_s_ready", bus.s_ready, 1'b0);
    chk("bp_out_valid", bus.out_valid, 1'b1);
    tick();
    tick();
    chk("hold_s_ready", bus.s_ready, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_valid", bus.out_valid, 1'b1);
    chk("release_data", bus.out_data, pack_row(e1));
    chk("release_s_ready", bus.s_ready, 1'b1);
    bus.out_ready = 1'b1;
    rand_row(e);
    send_row(e, -1);
    rand_row(e);
    send_row(e, BEATS-1);
    end_matrix(1'b0);

    // Early s_last on overall beat 3
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b1;
    for (int r = 0; r < ROW; r++) begin
      rand_row(e);
      send_row(e, (r == 1 || r == ROW-1) ? BEATS-1 : -1);
      if (r == 1) begin
        tick();
        chk("early_last_err", err, CHK);
      end
    end
    end_matrix(CHK);

    // en pause mid-row while the slot drains
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b1;
    rand_row(e);
    send_row(e, -1);
    tick();
    bus.out_ready = 1'b0;
    rand_row(e);
    send_row(e, -1);
    rand_row(e);
    send_beat(pack_beat(e, 0), 1'b0);
    en = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data = pack_beat(e, 1);
    for (int c = 0; c < 5; c++) begin
      if (c == 1) bus.out_ready = 1'b1;
      tick();
      chk("pause_s_ready", bus.s_ready, 1'b0);
    end
    chk("pause_drained", bus.out_valid, 1'b0);
    en = 1'b1;
    send_beat(pack_beat(e, 1), 1'b0);
    exp_q.push_back(pack_row(e));
    rand_row(e);
    send_row(e, BEATS-1);
    end_matrix(1'b0);

    // Async reset mid-row, then a fresh matrix
    do_reset();
    en = 1'b1;
    bus.out_ready = 1'b1;
    rand_row(e);
    send_row(e, -1);
    tick();
    bus.out_ready = 1'b0;
    rand_row(e);
    send_beat(pack_beat(e, 0), 1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_data", bus.out_data, '0);
    chk("mid_rst_row_count", row_count, 0);
    chk("mid_rst_s_ready", bus.s_ready, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_err", err, 1'b0);
    tick();
    rst = 1'b0;
    en = 1'b1;
    bus.out_ready = 1'b1;
    for (int r = 0; r < ROW; r++) begin
      rand_row(e);
      send_row(e, (r == ROW-1) ? BEATS-1 : -1);
    end
    end_matrix(1'b0);

    // Random backpressure and input gaps
    for (int m = 0; m < 3; m++) begin
      do_reset();
      en = 1'b1;
      rnd_rdy = 1'b1;
      rnd_gap = 1'b1;
      for (int r = 0; r < ROW; r++) begin
        rand_row(e);
        send_row(e, (r == ROW-1) ? BEATS-1 : -1);
      end
      rnd_gap = 1'b0;
      end_matrix(1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
